// File: rtl/raster_cmd_if.sv
// Command channel into the raster stream head: one register write per accepted transfer.
interface raster_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_target;
    logic [11:0] cmd_reg;
    logic [11:0] cmd_data;

    modport master (output cmd_valid, cmd_target, cmd_reg, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_target, cmd_reg, cmd_data, output cmd_ready);
endinterface

// File: rtl/raster_cmd_source.sv
// Head-of-chain stream generator: a fixed programming window draining queued
// register writes, followed by a full background raster scan, every frame.
module raster_cmd_source #(
    parameter int unsigned  H_ACTIVE   = 640,
    parameter int unsigned  V_ACTIVE   = 480,
    parameter int unsigned  PROG_SLOTS = 32,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter logic [11:0]  BG_COLOR   = 12'h000,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    raster_cmd_if.slave      cmd_bus,
    output logic             program_out,
    output logic [10:0]      x_out,
    output logic [11:0]      y_out,
    output logic [11:0]      data_out,
    output logic             frame_start,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned SLOT_W = $clog2(PROG_SLOTS + 1);
    localparam int unsigned X_W    = 11;
    localparam int unsigned Y_W    = 12;

    typedef struct packed {
        logic [10:0] target;
        logic [11:0] reg_id;
        logic [11:0] data;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PROG, ST_SCAN} state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;

    cmd_t              mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              push_c;
    logic              pop_c;
    cmd_t              head_c;

    assign cmd_bus.cmd_ready = rst_n && (count < LVL_W'(FIFO_DEPTH));
    assign push_c            = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
    assign pop_c             = (state == ST_PROG) && (count != '0);
    assign head_c            = mem[rd_ptr];
    assign fifo_level        = count;

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{target: cmd_bus.cmd_target,
                             reg_id: cmd_bus.cmd_reg,
                             data:   cmd_bus.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer; each edge emits the word belonging to the state being left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            slot        <= '0;
            col         <= '0;
            row         <= '0;
            program_out <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            data_out    <= '0;
            frame_start <= 1'b0;
        end else begin
            program_out <= 1'b1;
            x_out       <= 11'h7FF;
            y_out       <= 12'hFFF;
            data_out    <= 12'h000;
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_PROG;
                        slot  <= '0;
                    end
                end
                ST_PROG: begin
                    if (pop_c) begin
                        x_out    <= head_c.target;
                        y_out    <= head_c.reg_id;
                        data_out <= head_c.data;
                    end
                    if (slot == SLOT_W'(PROG_SLOTS - 1)) begin
                        state <= ST_SCAN;
                        col   <= '0;
                        row   <= '0;
                    end else begin
                        slot <= slot + SLOT_W'(1);
                    end
                end
                ST_SCAN: begin
                    program_out <= 1'b0;
                    x_out       <= col;
                    y_out       <= row;
                    data_out    <= BG_COLOR;
                    frame_start <= (col == '0) && (row == '0);
                    if (col == X_W'(H_ACTIVE - 1)) begin
                        col <= '0;
                        if (row == Y_W'(V_ACTIVE - 1)) begin
                            row   <= '0;
                            slot  <= '0;
                            state <= enable ? ST_PROG : ST_IDLE;
                        end else begin
                            row <= row + Y_W'(1);
                        end
                    end else begin
                        col <= col + X_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/raster_cmd_source.md
Name: raster_cmd_source

Overview:
Head-of-chain stream generator for the shape-renderer pipeline. Emits one word per clock on the common stream bus (program, x, y, data). Each frame is a programming window that drains queued register writes into downstream renderers, followed by a full raster scan of background pixels that the renderers overwrite.

Parameters:
H_ACTIVE, 640, pixels per line (x range 0..H_ACTIVE-1, max 2048)
V_ACTIVE, 480, lines per frame (y range 0..V_ACTIVE-1, max 4096)
PROG_SLOTS, 32, cycles in the programming window per frame (>=1)
FIFO_DEPTH, 16, command FIFO entries (power of 2, >=2)
BG_COLOR, 12'h000, data value on every scan pixel

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/continue frame generation
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (combinational: count < FIFO_DEPTH and rst_n high)
cmd_target  in  11  renderer index in chain (0 = first renderer)
cmd_reg  in  12  renderer register ID
cmd_data  in  12  register value
program_out  out  1  stream: 1 = programming word
x_out  out  11  stream x / target index
y_out  out  12  stream y / register ID
data_out  out  12  stream data / register value
frame_start  out  1  high with pixel (0,0) only
fifo_level  out  5  entries held (width covers FIFO_DEPTH=16)

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, counters 0; program_out=0, x_out=0, y_out=0, data_out=0, frame_start=0, fifo_level=0.
- All stream outputs registered. The word for a state/counter value appears after the edge that leaves that state.
- Push: cmd_valid && cmd_ready at an edge stores {target, reg, data}. Never accepted when full. Pop and push may coincide; level unchanged.
- Pop occurs only when count>0 at the edge, so a command pushed into an empty FIFO is emittable no earlier than the next edge. Commands emit strictly in push order.
- Command word: program_out=1, x_out=cmd_target, y_out=cmd_reg, data_out=cmd_data. Each renderer decrements x when forwarding a program word, so renderer k matches at x==0.
- Idle word: program_out=1, x_out=11'h7FF, y_out=12'hFFF, data_out=0. Matches no register ID.
- IDLE: emit idle word each cycle. If enable is high at an edge, go to PROG with slot=0.
- PROG: each cycle, pop and emit a command word if the FIFO is non-empty, else emit the idle word. slot increments. After the cycle with slot=PROG_SLOTS-1, go to SCAN with col=0, row=0. Window length is fixed regardless of FIFO contents.
- SCAN: emit program_out=0, x_out=col, y_out=row, data_out=BG_COLOR. frame_start=1 only for (0,0). col wraps at H_ACTIVE-1 and increments row. After (H_ACTIVE-1, V_ACTIVE-1): go to PROG if enable is high, else IDLE.
- Frame period = PROG_SLOTS + H_ACTIVE*V_ACTIVE cycles, constant.
- enable deassert mid-PROG or mid-SCAN: the current frame completes, then IDLE. The FIFO is retained.
- Commands pushed during SCAN wait for the next PROG window. Commands left over when the window ends stay queued.
- Reset mid-frame: immediate return to reset values. FIFO contents are discarded.

Test Plan:
- Params H=4, V=3, SLOTS=4, DEPTH=4. Reset, enable=1, no commands -> 4 idle words (1,7FF,FFF,000), then 12 pixels (0,0)..(3,2) with data 000, frame_start only on (0,0). Then the next PROG window; period 16.
- Push (target 2, reg 4, data ABC) and (0,0,123) before enable -> PROG emits (1,2,4,ABC), then (1,0,0,123), then 2 idle words.
- Push 4 commands -> cmd_ready=0, fifo_level=4, 5th push refused. Next PROG pops all 4 in order; level back to 0.
- Push 6 commands during SCAN (2 refused until space) -> only 4 emitted in the window. Commands pushed after that wait for the following frame.
- Drop enable at pixel (1,1) -> frame finishes at (3,2), then continuous idle words in IDLE. Re-enable -> PROG starts next edge.
- Assert rst_n low mid-SCAN with 2 queued -> outputs 0 immediately, fifo_level=0. After release, IDLE with no stale commands emitted.
